// File: rtl/taus_pkg.sv
// taus_pkg: shared types and constants for the Tausworthe generator and checker
package taus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } taus_fsm_t;
  localparam logic [31:0] SEED0_MIN = 32'd2;
  localparam logic [31:0] SEED1_MIN = 32'd8;
  localparam logic [31:0] SEED2_MIN = 32'd16;
  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } taus_state_t;
  function automatic logic seed_legal(taus_state_t s);
    return s.s0 >= SEED0_MIN && s.s1 >= SEED1_MIN && s.s2 >= SEED2_MIN;
  endfunction
endpackage

// File: rtl/taus_step.sv
// taus_step: one combinational step of the three-component Tausworthe generator
module taus_step
  import taus_pkg::*;
(
  input  taus_state_t cur,
  output taus_state_t nxt,
  output logic [31:0] word
);
  // next component states and their xor as the output word
  always_comb begin
    nxt.s0 = {cur.s0[19:1], cur.s0[18:6] ^ cur.s0[31:19]};
    nxt.s1 = {cur.s1[27:3], cur.s1[29:23] ^ cur.s1[31:25]};
    nxt.s2 = {cur.s2[14:4], cur.s2[28:8] ^ cur.s2[31:11]};
    word   = nxt.s0 ^ nxt.s1 ^ nxt.s2;
  end
endmodule

// File: rtl/taus_checker.sv
// taus_checker: tracks a local Tausworthe copy and checks the received urng stream against it
module taus_checker
  import taus_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 8,
  parameter int LOSS_N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic [31:0]      urng_seed1,
  input  logic [31:0]      urng_seed2,
  input  logic [31:0]      urng_seed3,
  input  logic [31:0]      urng_in,
  input  logic             urng_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             seed_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [1:0]       state
);
  taus_state_t st, st_nxt, seeds;
  taus_fsm_t   cs, ns;
  logic [31:0] exp_word;
  logic        legal, take, cmp_v, cmp_miss;
  logic [7:0]  run, miss;

  assign seeds = {urng_seed1, urng_seed2, urng_seed3};
  assign legal = seed_legal(seeds);
  assign take  = urng_valid && !seed_load && cs != ST_IDLE;

  taus_step u_step (.cur(st), .nxt(st_nxt), .word(exp_word));

  // compare stage: step the local state per accepted word and register the match result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= '0;
      cmp_v    <= 1'b0;
      cmp_miss <= 1'b0;
    end else begin
      if (seed_load && legal) st <= seeds;
      else if (take) st <= st_nxt;
      cmp_v    <= take;
      cmp_miss <= urng_in != exp_word;
    end
  end

  // result stage: pulse, saturating counters, run/miss tracking; a load drops any in-flight result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse  <= 1'b0;
      seed_err   <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      run        <= '0;
      miss       <= '0;
    end else if (seed_load) begin
      err_pulse  <= 1'b0;
      seed_err   <= !legal;
      err_count  <= '0;
      word_count <= '0;
      run        <= '0;
      miss       <= '0;
    end else if (cmp_v) begin
      err_pulse  <= cmp_miss;
      err_count  <= err_count + CNT_W'(cmp_miss && err_count != '1);
      word_count <= word_count + CNT_W'(word_count != '1);
      run        <= cs != ST_ACQUIRE ? run : cmp_miss ? 8'd0 : run + 8'd1;
      miss       <= cs != ST_LOCKED ? miss : cmp_miss ? miss + 8'd1 : 8'd0;
    end else begin
      err_pulse  <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cs <= ST_IDLE;
    else cs <= ns;
  end

  // FSM next state: loads override, otherwise only registered compare results move it
  always_comb begin
    ns = seed_load ? (legal ? ST_ACQUIRE : ST_IDLE) :
         !cmp_v ? cs :
         (cs == ST_ACQUIRE && !cmp_miss && run == 8'(LOCK_N - 1)) ? ST_LOCKED :
         (cs == ST_LOCKED && cmp_miss && miss == 8'(LOSS_N - 1)) ? ST_LOST : cs;
  end

  // FSM outputs
  always_comb begin
    locked = cs == ST_LOCKED;
    state  = cs;
  end
endmodule

// File: tb/tb_taus_checker.sv
// tb_taus_checker: scoreboard bench with a high-level reference model, two counter widths
module tb_taus_checker;
  localparam int LOCK_N = 8;
  localparam int LOSS_N = 4;

  logic clk = 1'b0, reset_n = 1'b1, seed_load = 1'b0, urng_valid = 1'b0;
  logic [31:0] urng_seed1 = '0, urng_seed2 = '0, urng_seed3 = '0, urng_in = '0;
  logic locked_a, err_pulse_a, seed_err_a, locked_b, err_pulse_b, seed_err_b;
  logic [15:0] err_count_a, word_count_a;
  logic [3:0] err_count_b, word_count_b;
  logic [1:0] state_a, state_b;

  taus_checker #(.CNT_W(16), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut_a (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .urng_seed1(urng_seed1),
    .urng_seed2(urng_seed2), .urng_seed3(urng_seed3), .urng_in(urng_in), .urng_valid(urng_valid),
    .locked(locked_a), .err_pulse(err_pulse_a), .seed_err(seed_err_a),
    .err_count(err_count_a), .word_count(word_count_a), .state(state_a));

  taus_checker #(.CNT_W(4), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut_b (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .urng_seed1(urng_seed1),
    .urng_seed2(urng_seed2), .urng_seed3(urng_seed3), .urng_in(urng_in), .urng_valid(urng_valid),
    .locked(locked_b), .err_pulse(err_pulse_b), .seed_err(seed_err_b),
    .err_count(err_count_b), .word_count(word_count_b), .state(state_b));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a, b, c; } tst_t;
  typedef struct { int due; bit pulse; bit lk; bit se; int ec; int wc; int st; } ent_t;

  ent_t q[$];
  ent_t vis;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  tst_t gen, mst;
  int m_mode, m_run, m_miss, m_ec, m_wc;
  bit m_se;

  always @(posedge clk) cyc <= cyc + 1;

  // classic taus88 formulation of one generator step
  function automatic tst_t tnext(tst_t s);
    tst_t n;
    n.a = ((s.a & 32'hFFFF_FFFE) << 12) ^ (((s.a << 13) ^ s.a) >> 19);
    n.b = ((s.b & 32'hFFFF_FFF8) << 4) ^ (((s.b << 2) ^ s.b) >> 25);
    n.c = ((s.c & 32'hFFFF_FFF0) << 17) ^ (((s.c << 3) ^ s.c) >> 11);
    return n;
  endfunction

  function automatic int sat(int c, int w);
    return c > (1 << w) - 1 ? (1 << w) - 1 : c;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(int due, bit pulse);
    ent_t e;
    e = '{due, pulse, m_mode == 2, m_se, m_ec, m_wc, m_mode};
    q.push_back(e);
  endtask

  // drive one cycle of inputs and advance the reference model accordingly
  task automatic step_cycle(bit ld, bit v, logic [31:0] w);
    tst_t n;
    bit bad;
    @(posedge clk); #1;
    seed_load = ld; urng_valid = v; urng_in = w;
    if (ld) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      m_se = !(urng_seed1 > 1 && urng_seed2 > 7 && urng_seed3 > 15);
      m_mode = m_se ? 0 : 1;
      m_run = 0; m_miss = 0; m_ec = 0; m_wc = 0;
      if (!m_se) mst = '{urng_seed1, urng_seed2, urng_seed3};
      push(cyc + 1, 1'b0);
    end else if (v && m_mode != 0) begin
      n = tnext(mst);
      bad = w != (n.a ^ n.b ^ n.c);
      mst = n;
      m_wc++;
      if (bad) m_ec++;
      if (m_mode == 1) begin
        m_run = bad ? 0 : m_run + 1;
        if (m_run == LOCK_N) m_mode = 2;
      end else if (m_mode == 2) begin
        m_miss = bad ? m_miss + 1 : 0;
        if (m_miss == LOSS_N) m_mode = 3;
      end
      push(cyc + 2, bad);
    end
  endtask

  task automatic send(bit v, int flip);
    logic [31:0] w;
    w = $urandom;
    if (v) begin
      gen = tnext(gen);
      w = gen.a ^ gen.b ^ gen.c;
      if (flip >= 0) w[flip] = ~w[flip];
    end
    step_cycle(1'b0, v, w);
  endtask

  task automatic load(logic [31:0] a, logic [31:0] b, logic [31:0] c, bit v);
    urng_seed1 = a; urng_seed2 = b; urng_seed3 = c;
    gen = '{a, b, c};
    step_cycle(1'b1, v, $urandom);
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #1;
    reset_n = 1'b0; seed_load = 1'b0; urng_valid = 1'b0;
    q.delete();
    vis = '{0, 0, 0, 0, 0, 0, 0};
    m_mode = 0; m_run = 0; m_miss = 0; m_ec = 0; m_wc = 0; m_se = 0; mst = '0;
    repeat (n) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) send(1'b0, -1);
  endtask

  // monitor: applies each result when due, checks every output of both instances each cycle
  always @(negedge clk) begin
    bit p;
    p = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      vis = q.pop_front();
      p = vis.pulse;
    end
    chk("locked_a", locked_a, vis.lk);
    chk("err_pulse_a", err_pulse_a, p);
    chk("seed_err_a", seed_err_a, vis.se);
    chk("err_count_a", err_count_a, sat(vis.ec, 16));
    chk("word_count_a", word_count_a, sat(vis.wc, 16));
    chk("state_a", state_a, vis.st);
    chk("locked_b", locked_b, vis.lk);
    chk("err_pulse_b", err_pulse_b, p);
    chk("seed_err_b", seed_err_b, vis.se);
    chk("err_count_b", err_count_b, sat(vis.ec, 4));
    chk("word_count_b", word_count_b, sat(vis.wc, 4));
    chk("state_b", state_b, vis.st);
  end

  initial begin
    vis = '{0, 0, 0, 0, 0, 0, 0};
    do_reset(3);
    idle(2);
    // clean stream locks after the eighth result
    load(32'h1000, 32'h2000, 32'h4000, 1'b0);
    for (int i = 1; i <= 20; i++) send(1'b1, -1);
    idle(3);
    // single flipped bit on word 5 restarts acquisition
    load(32'h1000, 32'h2000, 32'h4000, 1'b0);
    for (int i = 1; i <= 20; i++) send(1'b1, i == 5 ? 0 : -1);
    idle(2);
    // four consecutive bad words in LOCKED lose lock, LOST keeps counting
    for (int i = 0; i < 4; i++) send(1'b1, int'($urandom_range(31)));
    for (int i = 0; i < 3; i++) send(1'b1, -1);
    idle(2);
    load(32'h1234_5678, 32'h9abc_def0, 32'h0fed_cba9, 1'b0);
    idle(2);
    // illegal seed parks the checker in IDLE
    load(32'd1, 32'h2000, 32'h4000, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, -1);
    idle(2);
    // load coincident with a valid word, then a gappy stream
    load($urandom | 32'h2, $urandom | 32'h8, $urandom | 32'h10, 1'b1);
    for (int i = 0; i < 40; i++) send(1'(($urandom_range(1))), -1);
    idle(2);
    // drive into LOST and saturate the narrow counters, then reset mid-stream
    for (int i = 0; i < 24; i++) send(1'b1, int'($urandom_range(31)));
    for (int i = 0; i < 3; i++) send(1'b1, -1);
    do_reset(2);
    for (int i = 0; i < 5; i++) send(1'b1, -1);
    // random sessions: random seeds (sometimes illegal), gaps, sparse corruption, coincident loads
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(2) == 0) load($urandom_range(20), $urandom_range(20), $urandom_range(40), 1'($urandom_range(1)));
      else load($urandom | 32'h2, $urandom | 32'h8, $urandom | 32'h10, 1'($urandom_range(1)));
      for (int i = 0; i < 30; i++)
        send(1'($urandom_range(3) != 0), $urandom_range(9) == 0 ? int'($urandom_range(31)) : -1);
    end
    idle(4);
    chk("scoreboard_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
